// File: rtl/delay_path_sequencer.sv
// Launches transitions into a delay chain, times the synchronised return edge,
// and accumulates total/min/max latency over a programmable number of trials.
module delay_path_sequencer #(
  parameter int CNT_W       = 16,
  parameter int TRIAL_W     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [TRIAL_W-1:0]       num_trials,
  output logic                     path_launch,
  input  logic                     path_result,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [TRIAL_W-1:0]       trial_count,
  output logic [CNT_W+TRIAL_W-1:0] total_cycles,
  output logic [CNT_W-1:0]         min_cycles,
  output logic [CNT_W-1:0]         max_cycles
);

  localparam int TOT_W = CNT_W + TRIAL_W;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LAUNCH, S_MEASURE, S_RECORD, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                launch_q, launch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TRIAL_W-1:0]  num_q, num_d;
  logic [TRIAL_W-1:0]  trial_q, trial_d;
  logic [TOT_W-1:0]    total_q, total_d;
  logic [CNT_W-1:0]    min_q, min_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic                tmo_q, tmo_d;
  logic                sync_res;
  logic                match;
  logic [TRIAL_W-1:0]  trial_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], path_result};
  end

  assign sync_res  = sync_q[SYNC_STAGES-1];
  assign match     = (sync_res == launch_q);
  assign trial_inc = trial_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      launch_q <= 1'b0;
      cnt_q    <= '0;
      num_q    <= '0;
      trial_q  <= '0;
      total_q  <= '0;
      min_q    <= '0;
      max_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      trial_q  <= trial_d;
      total_q  <= total_d;
      min_q    <= min_d;
      max_q    <= max_d;
      tmo_q    <= tmo_d;
    end
  end

  // In MEASURE the counter freezes on match, so cnt_q holds the latency in RECORD.
  always_comb begin
    state_d  = state_q;
    launch_d = launch_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    trial_d  = trial_q;
    total_d  = total_q;
    min_d    = min_q;
    max_d    = max_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = num_trials;
          trial_d = '0;
          total_d = '0;
          min_d   = '1;
          max_d   = '0;
          tmo_d   = 1'b0;
          cnt_d   = '0;
          state_d = (num_trials == '0) ? S_DONE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (match) begin
          state_d = S_LAUNCH;
        end else if (cnt_q == TMO) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LAUNCH: begin
        launch_d = ~launch_q;
        cnt_d    = '0;
        state_d  = S_MEASURE;
      end
      S_MEASURE: begin
        if (match) begin
          state_d = S_RECORD;
        end else if (cnt_q == TMO) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RECORD: begin
        total_d = total_q + TOT_W'(cnt_q);
        if (cnt_q < min_q) min_d = cnt_q;
        if (cnt_q > max_q) max_d = cnt_q;
        trial_d = trial_inc;
        state_d = (trial_inc == num_q) ? S_DONE : S_LAUNCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign path_launch  = launch_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign timeout_err  = tmo_q;
  assign trial_count  = trial_q;
  assign total_cycles = total_q;
  assign min_cycles   = min_q;
  assign max_cycles   = max_q;

endmodule

// File: tb/tb_delay_path_sequencer.sv
// Scoreboard bench: expected run results are queued at start and checked on each done pulse.
module tb_delay_path_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  num_trials;
  logic        path_launch;
  logic        path_result;
  logic        busy, done, timeout_err;
  logic [7:0]  trial_count;
  logic [23:0] total_cycles;
  logic [15:0] min_cycles, max_cycles;

  int          mode;      // 0 loopback, 1 five-cycle delay, 2 stuck at 0
  logic [4:0]  dly_q;
  int          total_n = 0;
  int          bad_n   = 0;
  int          done_seen = 0;
  int          toggles = 0;
  logic        launch_prev = 1'b0;

  typedef struct {
    logic [7:0]  trials;
    logic [23:0] total;
    logic [15:0] mn;
    logic [15:0] mx;
    logic        tmo;
  } exp_t;
  exp_t exp_q[$];

  delay_path_sequencer #(
    .CNT_W(16), .TRIAL_W(8), .SYNC_STAGES(2), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_trials(num_trials),
    .path_launch(path_launch), .path_result(path_result), .busy(busy),
    .done(done), .timeout_err(timeout_err), .trial_count(trial_count),
    .total_cycles(total_cycles), .min_cycles(min_cycles), .max_cycles(max_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dly_q <= {dly_q[3:0], path_launch};

  assign path_result = (mode == 0) ? path_launch :
                       (mode == 1) ? dly_q[4] : 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_n++;
    if (act !== req) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (path_launch !== launch_prev) toggles++;
    launch_prev = path_launch;
    if (rst_n && done === 1'b1) begin
      exp_t e;
      done_seen++;
      if (exp_q.size() == 0) begin
        total_n++;
        bad_n++;
        $display("FAIL unexpected_done: got done=1 expected no pending run");
      end else begin
        e = exp_q.pop_front();
        chk("sb_trial_count", 32'(trial_count), 32'(e.trials));
        chk("sb_total_cycles", 32'(total_cycles), 32'(e.total));
        chk("sb_min_cycles", 32'(min_cycles), 32'(e.mn));
        chk("sb_max_cycles", 32'(max_cycles), 32'(e.mx));
        chk("sb_timeout_err", 32'(timeout_err), 32'(e.tmo));
      end
    end
  end

  task automatic do_start(input logic [7:0] n);
    @(negedge clk);
    num_trials = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [7:0] n, input exp_t e);
    exp_q.push_back(e);
    do_start(n);
  endtask

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (done !== 1'b1) begin
      total_n++;
      bad_n++;
      $display("FAIL %s_wait: got no done expected done within 500 cycles", nm);
    end
    @(negedge clk);
    chk({nm, "_busy_after_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int d0, k, c;
    rst_n = 1'b0; start = 1'b0; num_trials = 8'd0; mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_launch", 32'(path_launch), 32'd0);
    chk("rst_min", 32'(min_cycles), 32'd0);
    rst_n = 1'b1;

    // A: loopback, 4 trials
    toggles = 0; d0 = done_seen;
    run(8'd4, exp_t'{8'd4, 24'd8, 16'd2, 16'd2, 1'b0});
    wait_done("A");
    chk("A_done_count", 32'(done_seen - d0), 32'd1);
    chk("A_toggles", 32'(toggles), 32'd4);

    // B: five-cycle registered delay, 3 trials
    mode = 1;
    repeat (8) @(negedge clk);
    toggles = 0;
    run(8'd3, exp_t'{8'd3, 24'd21, 16'd7, 16'd7, 1'b0});
    wait_done("B");
    chk("B_toggles", 32'(toggles), 32'd3);
    chk("B_launch_end", 32'(path_launch), 32'd1);

    // C: zero trials
    mode = 0; toggles = 0;
    run(8'd0, exp_t'{8'd0, 24'd0, 16'hFFFF, 16'd0, 1'b0});
    chk("C_done_2nd_cycle", 32'(done), 32'd1);
    @(negedge clk);
    chk("C_busy_after_done", 32'(busy), 32'd0);
    chk("C_toggles", 32'(toggles), 32'd0);

    // D: start while busy with a different count is ignored
    d0 = done_seen;
    run(8'd3, exp_t'{8'd3, 24'd6, 16'd2, 16'd2, 1'b0});
    repeat (4) @(negedge clk);
    num_trials = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; num_trials = 8'd7;
    wait_done("D");
    repeat (5) @(negedge clk);
    chk("D_done_count", 32'(done_seen - d0), 32'd1);

    // E: stuck result, timeout 20
    mode = 2;
    repeat (4) @(negedge clk);
    run(8'd2, exp_t'{8'd0, 24'd0, 16'hFFFF, 16'd0, 1'b1});
    k = 0;
    while (path_launch !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    c = 0;
    while (done !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("E_timeout_latency", 32'(c), 32'd21);
    @(negedge clk);
    chk("E_busy_after_done", 32'(busy), 32'd0);

    // F: asynchronous reset mid-MEASURE, then a fresh single trial
    mode = 0;
    do_start(8'd3);
    k = 0;
    while (path_launch !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("F_rst_launch", 32'(path_launch), 32'd0);
    chk("F_rst_busy", 32'(busy), 32'd0);
    chk("F_rst_done", 32'(done), 32'd0);
    chk("F_rst_tmo", 32'(timeout_err), 32'd0);
    chk("F_rst_trials", 32'(trial_count), 32'd0);
    chk("F_rst_total", 32'(total_cycles), 32'd0);
    chk("F_rst_min", 32'(min_cycles), 32'd0);
    chk("F_rst_max", 32'(max_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'd1, exp_t'{8'd1, 24'd2, 16'd2, 16'd2, 1'b0});
    wait_done("F");

    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
